axil_mem_bridge: RTL and testbench
==================================

# axil_mem_bridge

AXI4-Lite slave that fronts the DPI-C simulation memory: it accepts one read or write transaction at a time from the core's bus, waits a programmable number of cycles to model memory latency, issues a single-cycle access on the downstream memory port, and returns the AXI response. It sits directly upstream of the DPI memory model, which performs the actual read or write in the same cycle as the strobe. Address range checking is done here, so out-of-range accesses never reach the memory model.

## Interface

- LATENCY, 1 — cycles from address handshake to the memory strobe; legal range 1..255.
- BASE, 32'h8000_0000 — first valid byte address.
- SIZE, 32'h0800_0000 — window size in bytes; valid iff BASE <= addr <= BASE+SIZE-1, computed without 32-bit wrap.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_araddr  in  32 / s_arvalid  in  1 / s_arready  out  1  — read address channel.
- s_rdata  out  32 / s_rresp  out  2 / s_rvalid  out  1 / s_rready  in  1  — read data channel.
- s_awaddr  in  32 / s_awvalid  in  1 / s_awready  out  1  — write address channel.
- s_wdata  in  32 / s_wstrb  in  4 / s_wvalid  in  1 / s_wready  out  1  — write data channel.
- s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1  — write response channel.
- mem_ren  out  1 / mem_raddr  out  32 / mem_rdata  in  32  — downstream read port; mem_rdata is valid combinationally in the cycle mem_ren is high.
- mem_wen  out  1 / mem_waddr  out  32 / mem_wdata  out  32 / mem_wmask  out  4  — downstream write port.

## Operation

- FSM states: IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP.
- IDLE: s_awready = s_wready = s_awvalid & s_wvalid; s_arready = s_arvalid & ~(s_awvalid & s_wvalid). AW and W always handshake in the same cycle. On a simultaneous write and read, the write wins and the read stays pending.
- On AR handshake: latch the address and the in-range flag, load cnt = LATENCY-1, and go to R_WAIT. AW/W handshake: latch the address, wdata, wstrb and in-range flag, load cnt, and go to W_WAIT.
- R_WAIT/W_WAIT: decrement cnt each cycle. In the cycle with cnt == 0:
  - In range: pulse the strobe for exactly one cycle. For reads, capture mem_rdata into s_rdata at that edge.
  - Out of range: no strobe; s_rdata = 0.
  - Then go to R_RESP/W_RESP.
- Address lines are word-aligned: mem_raddr/mem_waddr = latched addr & ~3. mem_wdata = latched wdata; mem_wmask = latched wstrb.
- A write with wstrb = 0 still pulses mem_wen, with mem_wmask = 0.
- Response codes: s_rresp/s_bresp = 2'b00 (OKAY) in range, 2'b10 (SLVERR) out of range.
- R_RESP: s_rvalid = 1 and held with stable data/resp until s_rready; go to IDLE on the handshake edge. W_RESP is the same with s_bvalid/s_bready.
- Only one transaction is outstanding; all readies are 0 outside IDLE.
- mem_ren/mem_wen are never high outside the strobe cycle, never both high, and mem_* address/data are held stable outside strobes (last latched values).

## Timing

- Reset (rst_n low at an edge) gives: state IDLE, cnt 0, s_rvalid = s_bvalid = 0, s_rdata = 0, s_rresp = s_bresp = 0, mem_ren = mem_wen = 0, latched addr/data/strb = 0. Readies are combinational from state, so they are 0 during reset.
- Reset mid-transaction aborts it: no strobe issues and no response is produced.
- Handshake at edge T: the strobe is high in cycle T+LATENCY (cycle T+1 being the first cycle after the edge), and s_rvalid/s_bvalid rise in cycle T+LATENCY+1.
- A response already ready (rready/bready high) completes in that cycle, and IDLE accepts the next request in the following cycle. Peak throughput is one transaction per LATENCY+2 cycles.
- cnt is 8 bits wide; LATENCY = 1 loads 0, so the strobe fires in the first R_WAIT/W_WAIT cycle.

## Test plan

- Read in range: LATENCY=3, araddr=0x8000_0006, mem returns 0xDEADBEEF. Expect mem_raddr=0x8000_0004, mem_ren high for 1 cycle 3 cycles after the handshake, rvalid on the next cycle with rdata=0xDEADBEEF, rresp=0.
- Write with strobe: awaddr=0x8000_0010, wdata=0x1234_5678, wstrb=4'b0011, W presented 2 cycles after AW. Expect no handshake until both are valid, then exactly one mem_wen pulse with mask 0011 and bresp=0.
- Out of range: read 0x7FFF_FFFC and write 0x8800_0000. Expect SLVERR on both, no mem_ren/mem_wen, rdata=0.
- Simultaneous AR+AW+W in IDLE: expect the write serviced first; the read is accepted the cycle after the B handshake.
- Backpressure: hold rready low for 5 cycles. Expect rvalid, rdata and rresp stable, arready=0, and no extra mem_ren.
- Reset in R_WAIT with LATENCY=4: expect no mem_ren, rvalid=0, and a fresh read after reset completes normally.

Source files
------------

// File: rtl/axil_mem_bridge_if.sv
// ============================================================================
// axil_mem_bridge_if -- AXI4-Lite bus bundle between the core and the bridge.
// Rev 1.0
// ============================================================================
`default_nettype none

interface axil_mem_bridge_if;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;

    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;

    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;

    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    // Bus master side (core / testbench).
    modport master (
        output s_araddr, s_arvalid, input  s_arready,
        input  s_rdata, s_rresp, s_rvalid, output s_rready,
        output s_awaddr, s_awvalid, input  s_awready,
        output s_wdata, s_wstrb, s_wvalid, input  s_wready,
        input  s_bresp, s_bvalid, output s_bready
    );

    // Bridge side.
    modport slave (
        input  s_araddr, s_arvalid, output s_arready,
        output s_rdata, s_rresp, s_rvalid, input  s_rready,
        input  s_awaddr, s_awvalid, output s_awready,
        input  s_wdata, s_wstrb, s_wvalid, output s_wready,
        output s_bresp, s_bvalid, input  s_bready
    );
endinterface

`default_nettype wire

// File: rtl/axil_mem_bridge.sv
// ============================================================================
// axil_mem_bridge -- AXI4-Lite slave fronting a single-cycle simulation memory
// with programmable access latency and address-window checking.
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_mem_bridge #(
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter logic [31:0] SIZE    = 32'h0800_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,

    axil_mem_bridge_if.slave s_axil,

    output logic             mem_ren,
    output logic [31:0]      mem_raddr,
    input  wire logic [31:0] mem_rdata,

    output logic             mem_wen,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask
);

    localparam logic [7:0] CNT_LOAD    = 8'(LATENCY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_WAIT = 3'd1,
        R_RESP = 3'd2,
        W_WAIT = 3'd3,
        W_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        in_range_q, in_range_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        wr_req;

    // Window test done in 33 bits so BASE+SIZE may reach 2^32 without wrapping.
    function automatic logic addr_in_range(input logic [31:0] a);
        logic [32:0] a_ext;
        logic [32:0] lo;
        logic [32:0] hi;
        a_ext = {1'b0, a};
        lo    = {1'b0, BASE};
        hi    = lo + {1'b0, SIZE};
        return (a_ext >= lo) && (a_ext < hi);
    endfunction

    assign wr_req = s_axil.s_awvalid & s_axil.s_wvalid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        in_range_d = in_range_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        bresp_d    = bresp_q;

        s_axil.s_arready = 1'b0;
        s_axil.s_awready = 1'b0;
        s_axil.s_wready  = 1'b0;
        mem_ren          = 1'b0;
        mem_wen          = 1'b0;

        case (state_q)
            IDLE: begin
                // Readies are masked while reset is held so nothing handshakes.
                s_axil.s_awready = wr_req & rst_n;
                s_axil.s_wready  = wr_req & rst_n;
                s_axil.s_arready = s_axil.s_arvalid & ~wr_req & rst_n;
                if (wr_req) begin
                    addr_d     = s_axil.s_awaddr;
                    wdata_d    = s_axil.s_wdata;
                    wstrb_d    = s_axil.s_wstrb;
                    in_range_d = addr_in_range(s_axil.s_awaddr);
                    cnt_d      = CNT_LOAD;
                    state_d    = W_WAIT;
                end else if (s_axil.s_arvalid) begin
                    addr_d     = s_axil.s_araddr;
                    in_range_d = addr_in_range(s_axil.s_araddr);
                    cnt_d      = CNT_LOAD;
                    state_d    = R_WAIT;
                end
            end

            R_WAIT: begin
                if (cnt_q == 8'd0) begin
                    mem_ren = in_range_q & rst_n;
                    rdata_d = in_range_q ? mem_rdata : 32'd0;
                    rresp_d = in_range_q ? RESP_OKAY : RESP_SLVERR;
                    state_d = R_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            R_RESP: begin
                if (s_axil.s_rready) begin
                    state_d = IDLE;
                end
            end

            W_WAIT: begin
                if (cnt_q == 8'd0) begin
                    mem_wen = in_range_q & rst_n;
                    bresp_d = in_range_q ? RESP_OKAY : RESP_SLVERR;
                    state_d = W_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            W_RESP: begin
                if (s_axil.s_bready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            in_range_q <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= 2'b00;
            bresp_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            in_range_q <= in_range_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
        end
    end

    assign s_axil.s_rvalid = (state_q == R_RESP);
    assign s_axil.s_bvalid = (state_q == W_RESP);
    assign s_axil.s_rdata  = rdata_q;
    assign s_axil.s_rresp  = rresp_q;
    assign s_axil.s_bresp  = bresp_q;

    // Memory address/data lines simply reflect the last latched request.
    assign mem_raddr = {addr_q[31:2], 2'b00};
    assign mem_waddr = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wmask = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_mem_bridge.sv
// ============================================================================
// tb_axil_mem_bridge -- randomized self-checking bench with a transaction-level
// reference model, plus directed scenarios on a LATENCY=3 and a LATENCY=4 DUT.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axil_mem_bridge;

    localparam int          LAT  = 3;
    localparam int          LAT4 = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0800_0000;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    axil_mem_bridge_if axi ();
    axil_mem_bridge_if axi4 ();

    logic        mem_ren, mem_wen;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem4_ren, mem4_wen;
    logic [31:0] mem4_raddr, mem4_rdata, mem4_waddr, mem4_wdata;
    logic [3:0]  mem4_wmask;

    logic [31:0] sim_mem [16];
    logic [31:0] ref_mem [16];

    assign mem_rdata  = sim_mem[mem_raddr[5:2]];
    assign mem4_rdata = mem4_raddr ^ 32'h5A5A_5A5A;

    axil_mem_bridge #(.LATENCY(LAT), .BASE(BASE), .SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .s_axil(axi.slave),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask)
    );

    axil_mem_bridge #(.LATENCY(LAT4), .BASE(BASE), .SIZE(SIZE)) dut4 (
        .clk(clk), .rst_n(rst4_n), .s_axil(axi4.slave),
        .mem_ren(mem4_ren), .mem_raddr(mem4_raddr), .mem_rdata(mem4_rdata),
        .mem_wen(mem4_wen), .mem_waddr(mem4_waddr), .mem_wdata(mem4_wdata),
        .mem_wmask(mem4_wmask)
    );

    // Downstream simulation memory: writes land at the strobe edge.
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) sim_mem[mem_waddr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned x, lo, hi;
        x  = a;
        lo = BASE;
        hi = lo + SIZE - 1;
        return (x >= lo) && (x <= hi);
    endfunction

    // ---------------- transaction-level reference model ----------------
    bit          m_busy = 0, m_wr = 0, m_inr = 0;
    int          m_age  = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_strb = 0;

    always @(negedge clk) begin : compare
        bit wreq, hs_w, hs_r, strobe, rv, bv;
        if (!rst_n) begin
            chk("rst_arready", axi.s_arready, 0);
            chk("rst_awready", axi.s_awready, 0);
            chk("rst_wready",  axi.s_wready,  0);
            chk("rst_rvalid",  axi.s_rvalid,  0);
            chk("rst_bvalid",  axi.s_bvalid,  0);
            chk("rst_mem_ren", mem_ren, 0);
            chk("rst_mem_wen", mem_wen, 0);
            m_busy = 0;
        end else begin
            wreq   = axi.s_awvalid && axi.s_wvalid;
            hs_w   = !m_busy && wreq;
            hs_r   = !m_busy && axi.s_arvalid && !wreq;
            strobe = m_busy && (m_age == LAT) && m_inr;
            rv     = m_busy && !m_wr && (m_age > LAT);
            bv     = m_busy &&  m_wr && (m_age > LAT);
            chk("arready", axi.s_arready, hs_r);
            chk("awready", axi.s_awready, hs_w);
            chk("wready",  axi.s_wready,  hs_w);
            chk("mem_ren", mem_ren, strobe && !m_wr);
            chk("mem_wen", mem_wen, strobe && m_wr);
            chk("rvalid",  axi.s_rvalid, rv);
            chk("bvalid",  axi.s_bvalid, bv);
            if (strobe && !m_wr) chk("mem_raddr", mem_raddr, m_addr & ~32'd3);
            if (strobe && m_wr) begin
                chk("mem_waddr", mem_waddr, m_addr & ~32'd3);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_wmask", mem_wmask, m_strb);
            end
            if (rv) begin
                chk("rdata", axi.s_rdata, m_rdata);
                chk("rresp", axi.s_rresp, m_inr ? 32'd0 : 32'd2);
            end
            if (bv) chk("bresp", axi.s_bresp, m_inr ? 32'd0 : 32'd2);

            if (hs_w) begin
                m_busy = 1; m_wr = 1; m_age = 1;
                m_addr = axi.s_awaddr; m_wdata = axi.s_wdata; m_strb = axi.s_wstrb;
                m_inr  = in_win(axi.s_awaddr);
            end else if (hs_r) begin
                m_busy = 1; m_wr = 0; m_age = 1;
                m_addr = axi.s_araddr;
                m_inr  = in_win(axi.s_araddr);
            end else if (m_busy) begin
                if (m_age == LAT) begin
                    if (m_wr) begin
                        if (m_inr) begin
                            for (int b = 0; b < 4; b++)
                                if (m_strb[b]) ref_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
                        end
                    end else begin
                        m_rdata = m_inr ? ref_mem[m_addr[5:2]] : 32'd0;
                    end
                end
                if (m_age > LAT && (m_wr ? axi.s_bready : axi.s_rready)) m_busy = 0;
                m_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_r(input logic [31:0] a);
        bit hs = 0;
        axi.s_araddr  = a;
        axi.s_arvalid = 1'b1;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            hs = axi.s_arready;
            cyc();
        end
        axi.s_arvalid = 1'b0;
        chk("ar_handshake", hs, 1);
    endtask

    task automatic collect_r(output logic [31:0] d, output logic [1:0] r, output int nren,
                             output int sd, output logic [31:0] ra);
        bit got = 0;
        nren = 0; sd = -1; d = 32'hx; r = 2'bx; ra = 32'h0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (mem_ren) begin nren++; sd = i; ra = mem_raddr; end
            if (axi.s_rvalid && axi.s_rready) begin got = 1; d = axi.s_rdata; r = axi.s_rresp; end
            cyc();
        end
        chk("r_response_seen", got, 1);
    endtask

    task automatic issue_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int wdelay);
        bit hs = 0;
        axi.s_awaddr  = a;
        axi.s_awvalid = 1'b1;
        axi.s_wvalid  = 1'b0;
        for (int i = 0; i < wdelay; i++) begin
            @(negedge clk);
            chk("aw_alone_awready", axi.s_awready, 0);
            chk("aw_alone_wready",  axi.s_wready,  0);
            cyc();
        end
        axi.s_wdata  = d;
        axi.s_wstrb  = s;
        axi.s_wvalid = 1'b1;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            hs = axi.s_awready && axi.s_wready;
            cyc();
        end
        axi.s_awvalid = 1'b0;
        axi.s_wvalid  = 1'b0;
        chk("aw_w_handshake", hs, 1);
    endtask

    task automatic collect_b(output logic [1:0] r, output int nwen, output int sd,
                             output logic [31:0] wa, output logic [3:0] wm);
        bit got = 0;
        nwen = 0; sd = -1; r = 2'bx; wa = 32'h0; wm = 4'h0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (mem_wen) begin nwen++; sd = i; wa = mem_waddr; wm = mem_wmask; end
            if (axi.s_bvalid && axi.s_bready) begin got = 1; r = axi.s_bresp; end
            cyc();
        end
        chk("b_response_seen", got, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0: return 32'h7FFF_FFFC;
            1: return 32'h8800_0000;
            2: return 32'h87FF_FFFC + 32'($urandom_range(0, 3));
            default: return BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d0, ra, wa;
        logic [1:0]  r, r0;
        logic [3:0]  wm;
        int          n, sd, bcyc, arcyc, n4, rv4;
        bit          got;

        axi.s_araddr = 0; axi.s_arvalid = 0; axi.s_rready = 0;
        axi.s_awaddr = 0; axi.s_awvalid = 0; axi.s_wdata = 0; axi.s_wstrb = 0;
        axi.s_wvalid = 0; axi.s_bready = 0;
        axi4.s_araddr = 0; axi4.s_arvalid = 0; axi4.s_rready = 0;
        axi4.s_awaddr = 0; axi4.s_awvalid = 0; axi4.s_wdata = 0; axi4.s_wstrb = 0;
        axi4.s_wvalid = 0; axi4.s_bready = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            sim_mem[i] = ref_mem[i];
        end
        ref_mem[1] = 32'hDEAD_BEEF; sim_mem[1] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hAAAA_BBBB; sim_mem[4] = 32'hAAAA_BBBB;

        // Reset with every request valid: nothing may handshake.
        axi.s_arvalid = 1; axi.s_awvalid = 1; axi.s_wvalid = 1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_rdata", axi.s_rdata, 0);
        chk("rst_rresp", axi.s_rresp, 0);
        chk("rst_bresp", axi.s_bresp, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        cyc();
        axi.s_arvalid = 0; axi.s_awvalid = 0; axi.s_wvalid = 0;
        rst_n = 1; rst4_n = 1;
        cyc();

        // In-range read, misaligned address.
        axi.s_rready = 1; axi.s_bready = 1;
        issue_r(32'h8000_0006);
        collect_r(d, r, n, sd, ra);
        chk("rd_data", d, 32'hDEAD_BEEF);
        chk("rd_resp", r, 0);
        chk("rd_nren", n, 1);
        chk("rd_strobe_cycle", sd, 3);
        chk("rd_mem_raddr", ra, 32'h8000_0004);

        // Write with W arriving two cycles after AW.
        issue_w(32'h8000_0010, 32'h1234_5678, 4'b0011, 2);
        collect_b(r, n, sd, wa, wm);
        chk("wr_resp", r, 0);
        chk("wr_nwen", n, 1);
        chk("wr_strobe_cycle", sd, 3);
        chk("wr_mask", wm, 4'b0011);
        chk("wr_waddr", wa, 32'h8000_0010);
        issue_r(32'h8000_0010);
        collect_r(d, r, n, sd, ra);
        chk("wr_readback", d, 32'hAAAA_5678);

        // Out-of-range read and write.
        issue_r(32'h7FFF_FFFC);
        collect_r(d, r, n, sd, ra);
        chk("oor_rd_resp", r, 2);
        chk("oor_rd_nren", n, 0);
        chk("oor_rd_data", d, 0);
        issue_w(32'h8800_0000, 32'hFFFF_FFFF, 4'hF, 0);
        collect_b(r, n, sd, wa, wm);
        chk("oor_wr_resp", r, 2);
        chk("oor_wr_nwen", n, 0);

        // Simultaneous AR + AW + W: write first, read the cycle after B.
        axi.s_araddr = 32'h8000_000C; axi.s_arvalid = 1;
        axi.s_awaddr = 32'h8000_000C; axi.s_wdata = 32'h0BAD_F00D; axi.s_wstrb = 4'hF;
        axi.s_awvalid = 1; axi.s_wvalid = 1;
        @(negedge clk);
        chk("sim_awready", axi.s_awready, 1);
        chk("sim_arready", axi.s_arready, 0);
        cyc();
        axi.s_awvalid = 0; axi.s_wvalid = 0;
        bcyc = -1; arcyc = -1;
        for (int i = 1; i <= 40 && arcyc < 0; i++) begin
            @(negedge clk);
            if (axi.s_bvalid && axi.s_bready) bcyc = i;
            if (axi.s_arready) arcyc = i;
            cyc();
        end
        axi.s_arvalid = 0;
        chk("sim_b_cycle", bcyc, LAT + 1);
        chk("sim_ar_after_b", arcyc, bcyc + 1);
        collect_r(d, r, n, sd, ra);
        chk("sim_rd_data", d, 32'h0BAD_F00D);

        // Backpressure on R with another read waiting.
        axi.s_rready = 0;
        issue_r(32'h8000_0014);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (axi.s_rvalid) begin got = 1; d0 = axi.s_rdata; r0 = axi.s_rresp; end
            cyc();
        end
        chk("bp_rvalid_seen", got, 1);
        chk("bp_rdata", d0, ref_mem[5]);
        axi.s_araddr = 32'h8000_0018; axi.s_arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rvalid_hold", axi.s_rvalid, 1);
            chk("bp_rdata_hold", axi.s_rdata, d0);
            chk("bp_rresp_hold", axi.s_rresp, r0);
            chk("bp_arready", axi.s_arready, 0);
            chk("bp_no_ren", mem_ren, 0);
            cyc();
        end
        axi.s_rready = 1;
        cyc();
        issue_r(32'h8000_0018);
        collect_r(d, r, n, sd, ra);
        chk("bp_next_nren", n, 1);

        // Reset in R_WAIT on the LATENCY=4 instance.
        axi4.s_rready = 1;
        axi4.s_araddr = 32'h8000_0020; axi4.s_arvalid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = axi4.s_arready;
            cyc();
        end
        axi4.s_arvalid = 0;
        chk("r4_handshake", got, 1);
        n4 = 0; rv4 = 0;
        @(negedge clk);
        if (mem4_ren) n4++;
        if (axi4.s_rvalid) rv4++;
        cyc();
        rst4_n = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) rst4_n = 1;
            @(negedge clk);
            if (mem4_ren) n4++;
            if (axi4.s_rvalid) rv4++;
            cyc();
        end
        chk("r4_abort_no_ren", n4, 0);
        chk("r4_abort_no_rvalid", rv4, 0);
        axi4.s_arvalid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = axi4.s_arready;
            cyc();
        end
        axi4.s_arvalid = 0;
        chk("r4_fresh_handshake", got, 1);
        got = 0; sd = -1; d = 0; ra = 0; r = 2'bx;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            if (mem4_ren) begin sd = i; ra = mem4_raddr; end
            if (axi4.s_rvalid) begin got = 1; d = axi4.s_rdata; r = axi4.s_rresp; end
            cyc();
        end
        chk("r4_fresh_rvalid", got, 1);
        chk("r4_fresh_strobe_cycle", sd, LAT4);
        chk("r4_fresh_raddr", ra, 32'h8000_0020);
        chk("r4_fresh_rdata", d, 32'hDA5A_5A7A);
        chk("r4_fresh_rresp", r, 0);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 2500; c++) begin
            bit ar_hs, w_hs;
            @(negedge clk);
            ar_hs = axi.s_arvalid && axi.s_arready;
            w_hs  = axi.s_awvalid && axi.s_wvalid && axi.s_awready;
            cyc();
            if (!axi.s_arvalid || ar_hs) begin
                axi.s_arvalid = ($urandom_range(0, 2) == 0);
                axi.s_araddr  = rand_addr();
            end
            if (!axi.s_awvalid || w_hs) begin
                axi.s_awvalid = ($urandom_range(0, 2) == 0);
                axi.s_awaddr  = rand_addr();
            end
            if (!axi.s_wvalid || w_hs) begin
                axi.s_wvalid = ($urandom_range(0, 2) == 0);
                axi.s_wdata  = $urandom;
                axi.s_wstrb  = 4'($urandom_range(0, 15));
            end
            axi.s_rready = ($urandom_range(0, 3) != 0);
            axi.s_bready = ($urandom_range(0, 3) != 0);
        end
        axi.s_arvalid = 0; axi.s_awvalid = 0; axi.s_wvalid = 0;
        axi.s_rready = 1; axi.s_bready = 1;
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
